// File: rtl/store_channel_arbiter.sv
// Shares the single memory-controller store channel between the direct I/O
// store path and the store-buffer drain path; I/O first, bounded by a burst limit.
module store_channel_arbiter #(
  parameter int unsigned MAX_IO_BURST = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        io_request_i,
  input  logic [31:0] io_address_i,
  input  logic [31:0] io_data_i,
  input  logic [1:0]  io_width_i,
  output logic        io_done_o,
  input  logic        buf_empty_i,
  input  logic [31:0] buf_address_i,
  input  logic [31:0] buf_data_i,
  input  logic [1:0]  buf_width_i,
  output logic        buf_pop_o,
  input  logic        drain_i,
  output logic        drained_o,
  output logic        mem_request_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  output logic [1:0]  mem_width_o,
  input  logic        mem_done_i,
  output logic        idle_o
);

  // Handshake: a grant in IDLE (cycle T) latches the winner's payload, pops the
  // buffer head combinationally in T, pulses mem_request_o in T+1 and then waits
  // for a mem_done_i pulse no earlier than T+2 before returning to IDLE.
  typedef enum logic [1:0] {IDLE, IO_STORE, BUF_STORE} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_IO_BURST);

  state_t      state;
  logic [3:0]  burst_cnt;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  width_q;

  logic arb_en;
  logic burst_full;
  logic io_ok;
  logic grant_io;
  logic grant_buf;
  logic done_ok;

  always_comb begin
    arb_en     = (state == IDLE) && rst_n_i;
    // Once the limit is reached the buffer gets the next slot, but only if it has work.
    burst_full = (burst_cnt == MAX_CNT) && !buf_empty_i;
    io_ok      = io_request_i && !burst_full;
    grant_buf  = arb_en && !buf_empty_i && (drain_i || !io_ok);
    grant_io   = arb_en && io_ok && !(drain_i && !buf_empty_i);
    done_ok    = (state != IDLE) && !req_q && mem_done_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
      req_q     <= 1'b0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      width_q   <= 2'd0;
    end else begin
      req_q <= grant_io || grant_buf;
      if (grant_io) begin
        state   <= IO_STORE;
        addr_q  <= io_address_i;
        data_q  <= io_data_i;
        width_q <= io_width_i;
      end else if (grant_buf) begin
        state   <= BUF_STORE;
        addr_q  <= buf_address_i;
        data_q  <= buf_data_i;
        width_q <= buf_width_i;
      end else if (done_ok) begin
        state <= IDLE;
      end

      if (buf_empty_i || grant_buf) begin
        burst_cnt <= 4'd0;
      end else if (grant_io && (burst_cnt != MAX_CNT)) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  assign mem_request_o = req_q;
  assign mem_address_o = addr_q;
  assign mem_data_o    = data_q;
  assign mem_width_o   = width_q;
  assign buf_pop_o     = grant_buf;
  assign io_done_o     = done_ok && (state == IO_STORE);
  assign idle_o        = (state == IDLE);
  assign drained_o     = (state == IDLE) && buf_empty_i;

  a_pop_nonempty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    buf_pop_o |-> !buf_empty_i);

  a_req_single: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    mem_request_o |=> !mem_request_o);

  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    ((state != IDLE) && !req_q) |-> $stable({addr_q, data_q, width_q}));

endmodule

// File: tb/tb_store_channel_arbiter.sv
// Directed bench for store_channel_arbiter: queue-backed I/O and buffer
// requesters, a latency-programmable memory responder and an address scoreboard.
module tb_store_channel_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        io_request_i;
  logic [31:0] io_address_i;
  logic [31:0] io_data_i;
  logic [1:0]  io_width_i;
  logic        io_done_o;
  logic        buf_empty_i;
  logic [31:0] buf_address_i;
  logic [31:0] buf_data_i;
  logic [1:0]  buf_width_i;
  logic        buf_pop_o;
  logic        drain_i;
  logic        drained_o;
  logic        mem_request_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic [1:0]  mem_width_o;
  logic        mem_done_i;
  logic        idle_o;

  store_channel_arbiter #(.MAX_IO_BURST(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .io_request_i(io_request_i), .io_address_i(io_address_i),
    .io_data_i(io_data_i), .io_width_i(io_width_i), .io_done_o(io_done_o),
    .buf_empty_i(buf_empty_i), .buf_address_i(buf_address_i),
    .buf_data_i(buf_data_i), .buf_width_i(buf_width_i), .buf_pop_o(buf_pop_o),
    .drain_i(drain_i), .drained_o(drained_o),
    .mem_request_o(mem_request_o), .mem_address_o(mem_address_o),
    .mem_data_o(mem_data_o), .mem_width_o(mem_width_o),
    .mem_done_i(mem_done_i), .idle_o(idle_o)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_t[$];

  logic [31:0] io_aq[$], io_dq[$];
  logic [1:0]  io_wq[$];
  logic [31:0] buf_aq[$], buf_dq[$];
  logic [1:0]  buf_wq[$];

  logic auto_mem;
  int   mem_lat;
  int   done_cnt;
  logic io_pop, b_pop;
  int   io_done_seen;
  int   io_done_cyc;
  int   drained_cyc;
  int   pop_count;
  int   io_done_before;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    io_request_i  = (io_aq.size() != 0);
    io_address_i  = (io_aq.size() != 0) ? io_aq[0] : 32'd0;
    io_data_i     = (io_dq.size() != 0) ? io_dq[0] : 32'd0;
    io_width_i    = (io_wq.size() != 0) ? io_wq[0] : 2'd0;
    buf_empty_i   = (buf_aq.size() == 0);
    buf_address_i = (buf_aq.size() != 0) ? buf_aq[0] : 32'd0;
    buf_data_i    = (buf_dq.size() != 0) ? buf_dq[0] : 32'd0;
    buf_width_i   = (buf_wq.size() != 0) ? buf_wq[0] : 2'd0;
  endtask

  // One clock: observe at the falling edge, update requesters/responder just
  // after the rising edge, then let combinational outputs settle.
  task automatic tick();
    @(negedge clk_i);
    io_pop = io_done_o;
    b_pop  = buf_pop_o;
    if (buf_pop_o) pop_count++;
    if (io_done_o) begin
      io_done_seen++;
      io_done_cyc = cyc;
    end
    if (drained_o && drained_cyc < 0) drained_cyc = cyc;
    if (mem_request_o) begin
      got_q.push_back(mem_address_o);
      got_t.push_back(cyc);
      if (auto_mem) done_cnt = mem_lat;
    end
    @(posedge clk_i);
    cyc++;
    #1;
    if (io_pop) begin
      void'(io_aq.pop_front()); void'(io_dq.pop_front()); void'(io_wq.pop_front());
    end
    if (b_pop) begin
      void'(buf_aq.pop_front()); void'(buf_dq.pop_front()); void'(buf_wq.pop_front());
    end
    mem_done_i = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) mem_done_i = 1'b1;
    end
    drive_inputs();
    #1;
  endtask

  task automatic push_io(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    io_aq.push_back(a); io_dq.push_back(d); io_wq.push_back(w);
  endtask

  task automatic push_buf(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    buf_aq.push_back(a); buf_dq.push_back(d); buf_wq.push_back(w);
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n;
    n = 0;
    while (!(io_aq.size() == 0 && buf_aq.size() == 0 && idle_o && done_cnt == 0) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_in_time"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() != 0 && got_q.size() != 0)
      chk({tag, "_addr"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  initial begin
    rst_n_i = 1'b0; drain_i = 1'b0; mem_done_i = 1'b0;
    auto_mem = 1'b1; mem_lat = 1; done_cnt = 0;
    io_pop = 1'b0; b_pop = 1'b0; io_done_seen = 0; io_done_cyc = -1;
    drained_cyc = -1; pop_count = 0; io_done_before = 0;
    drive_inputs();

    // Reset state
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_mem_request", 32'(mem_request_o), 32'd0);
    chk("rst_buf_pop", 32'(buf_pop_o), 32'd0);
    chk("rst_io_done", 32'(io_done_o), 32'd0);
    chk("rst_mem_address", mem_address_o, 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    chk("rst_burst_cnt", 32'(dut.burst_cnt), 32'd0);
    rst_n_i = 1'b1;
    tick(); tick();
    chk("post_rst_drained", 32'(drained_o), 32'd1);

    // Single I/O store, done at T+3
    mem_lat = 2;
    push_io(32'h0000_1000, 32'hDEAD_BEEF, 2'd2);
    exp_q.push_back(32'h0000_1000);
    tick();
    chk("io_T_idle", 32'(idle_o), 32'd1);
    chk("io_T_req", 32'(mem_request_o), 32'd0);
    tick();
    chk("io_T1_req", 32'(mem_request_o), 32'd1);
    chk("io_T1_addr", mem_address_o, 32'h0000_1000);
    chk("io_T1_data", mem_data_o, 32'hDEAD_BEEF);
    chk("io_T1_width", 32'(mem_width_o), 32'd2);
    chk("io_T1_idle", 32'(idle_o), 32'd0);
    tick();
    chk("io_T2_req", 32'(mem_request_o), 32'd0);
    chk("io_T2_done", 32'(io_done_o), 32'd0);
    chk("io_T2_addr", mem_address_o, 32'h0000_1000);
    tick();
    chk("io_T3_done", 32'(io_done_o), 32'd1);
    tick();
    chk("io_T4_idle", 32'(idle_o), 32'd1);
    chk("io_T4_done", 32'(io_done_o), 32'd0);
    check_sb("io_single");

    // Buffer drain of three entries, one cycle memory latency
    mem_lat = 1;
    pop_count = 0;
    push_buf(32'h8000_0000, 32'h0000_00A0, 2'd2);
    push_buf(32'h8000_0004, 32'h0000_00B0, 2'd1);
    push_buf(32'h8000_0008, 32'h0000_00C0, 2'd0);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0004);
    exp_q.push_back(32'h8000_0008);
    wait_quiet("drain3", 40);
    chk("drain3_drained", 32'(drained_o), 32'd1);
    chk("drain3_pops", 32'(pop_count), 32'd3);
    if (got_t.size() == 3) begin
      chk("drain3_period_ab", 32'(got_t[1] - got_t[0]), 32'd3);
      chk("drain3_period_bc", 32'(got_t[2] - got_t[1]), 32'd3);
    end
    check_sb("drain3");

    // Priority: I/O beats a non-empty buffer
    push_io(32'h0000_2000, 32'h1111_2222, 2'd1);
    push_buf(32'h8000_0010, 32'h0000_3333, 2'd0);
    exp_q.push_back(32'h0000_2000);
    exp_q.push_back(32'h8000_0010);
    wait_quiet("prio", 40);
    check_sb("prio");

    // Starvation limit: four I/O grants, then the buffer head
    for (int i = 0; i < 6; i++)
      push_io(32'h0000_3000 + 32'(4 * i), 32'h0000_5000 + 32'(i), 2'd2);
    push_buf(32'h8000_0020, 32'h0000_6666, 2'd2);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_3000 + 32'(4 * i));
    exp_q.push_back(32'h8000_0020);
    exp_q.push_back(32'h0000_3010);
    exp_q.push_back(32'h0000_3014);
    wait_quiet("burst", 80);
    check_sb("burst");

    // Fence: drain empties the buffer ahead of a pending I/O store
    drain_i = 1'b1;
    push_buf(32'h8000_0030, 32'h0000_7777, 2'd2);
    push_buf(32'h8000_0034, 32'h0000_8888, 2'd2);
    push_io(32'h0000_4000, 32'h0000_9999, 2'd2);
    exp_q.push_back(32'h8000_0030);
    exp_q.push_back(32'h8000_0034);
    exp_q.push_back(32'h0000_4000);
    tick();
    drained_cyc = -1;
    io_done_cyc = -1;
    wait_quiet("fence", 60);
    drain_i = 1'b0;
    chk("fence_drained_first", 32'(drained_cyc >= 0 && drained_cyc < io_done_cyc), 32'd1);
    check_sb("fence");

    // Reset while a buffer store waits for completion
    mem_lat = 1;
    push_io(32'h0000_5000, 32'h0000_AAAA, 2'd2);
    push_buf(32'h8000_0040, 32'h0000_BBBB, 2'd2);
    push_buf(32'h8000_0044, 32'h0000_CCCC, 2'd2);
    exp_q.push_back(32'h0000_5000);
    exp_q.push_back(32'h8000_0040);
    exp_q.push_back(32'h8000_0044);
    tick();
    tick();
    tick();
    auto_mem = 1'b0;
    chk("rstx_io_done", 32'(io_done_o), 32'd1);
    tick();
    chk("rstx_buf_pop", 32'(buf_pop_o), 32'd1);
    tick();
    chk("rstx_buf_req", 32'(mem_request_o), 32'd1);
    tick();
    chk("rstx_busy", 32'(idle_o), 32'd0);
    io_done_before = io_done_seen;
    rst_n_i = 1'b0;
    #1;
    chk("rstx_async_req", 32'(mem_request_o), 32'd0);
    chk("rstx_async_idle", 32'(idle_o), 32'd1);
    chk("rstx_async_addr", mem_address_o, 32'd0);
    chk("rstx_async_pop", 32'(buf_pop_o), 32'd0);
    tick();
    chk("rstx_no_done", 32'(io_done_o), 32'd0);
    rst_n_i = 1'b1;
    auto_mem = 1'b1;
    chk("rstx_burst_cnt", 32'(dut.burst_cnt), 32'd0);
    wait_quiet("rstx", 40);
    chk("rstx_no_io_done", 32'(io_done_seen - io_done_before), 32'd0);
    check_sb("rstx");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_channel_arbiter.md
Name: store_channel_arbiter

Overview:
- Owns the single memory-controller store channel and shares it between two requesters.
- Requester 1 is the direct (non-bufferable, I/O region) store path from the store unit. Requester 2 is the store-buffer drain path, which pops the buffer head.
- I/O stores have priority. A bounded-burst counter keeps buffered stores from starving, and a drain input supports fences.
- Sits between the memory unit's store side and the memory controller. Its idle output is the store-controller-idle indication seen by the store unit.

Parameters:
- MAX_IO_BURST, 4, max consecutive I/O grants while the buffer is non-empty before one buffer grant is forced (range 1..15).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- io_request_i  in  1  direct store request; level, held until io_done_o.
- io_address_i  in  32  direct store address.
- io_data_i  in  32  direct store data.
- io_width_i  in  2  store width (0 byte, 1 half, 2 word).
- io_done_o  out  1  one-cycle pulse: direct store completed.
- buf_empty_i  in  1  store buffer empty.
- buf_address_i  in  32  buffer head address.
- buf_data_i  in  32  buffer head data.
- buf_width_i  in  2  buffer head width.
- buf_pop_o  out  1  one-cycle pop of the buffer head.
- drain_i  in  1  fence: empty the buffer before serving I/O.
- drained_o  out  1  buffer empty and arbiter idle.
- mem_request_o  out  1  one-cycle store request to the memory controller.
- mem_address_o  out  32  registered store address.
- mem_data_o  out  32  registered store data.
- mem_width_o  out  2  registered store width.
- mem_done_i  in  1  memory controller store complete, one-cycle pulse.
- idle_o  out  1  arbiter in IDLE.

Behaviour:
- Reset, asynchronous:
  - state = IDLE, burst counter = 0, payload registers = 0.
  - mem_request_o, buf_pop_o, io_done_o = 0; idle_o = 1.
  - Reset during a transfer abandons it. No done pulse is ever produced for that transfer.
- States: IDLE, IO_STORE, BUF_STORE.
- IDLE arbitration, evaluated in cycle T:
  - If drain_i and !buf_empty_i: grant buffer.
  - Else if io_request_i and !(burst counter == MAX_IO_BURST and !buf_empty_i): grant I/O.
  - Else if !buf_empty_i: grant buffer.
  - Else stay in IDLE.
- On a grant in cycle T:
  - The winner's address, data and width are latched at the end of T.
  - A buffer grant asserts buf_pop_o combinationally in cycle T only.
  - Next state is IO_STORE or BUF_STORE.
- Transfer states:
  - mem_request_o = 1 only in the first cycle (T+1).
  - mem_address_o, mem_data_o and mem_width_o are held stable from T+1 until the cycle mem_done_i is seen.
  - mem_done_i is ignored outside transfer states and in the request cycle T+1; the earliest accepted done is T+2.
  - On mem_done_i in IO_STORE: io_done_o = 1 that same cycle, and the next state is IDLE.
  - On mem_done_i in BUF_STORE: next state is IDLE.
  - No timeout; the arbiter waits indefinitely.
- Back-to-back operation: the next grant happens no earlier than the cycle after the return to IDLE. Minimum period is 3 cycles per store (grant, request, done).
- Burst counter, 4 bits, saturating at MAX_IO_BURST:
  - Increments on an I/O grant while buf_empty_i = 0.
  - Clears on any buffer grant, and in any cycle where buf_empty_i = 1.
- Outputs:
  - idle_o = (state == IDLE).
  - drained_o = idle_o and buf_empty_i (combinational).
- Simultaneous events:
  - io_request_i together with a non-empty buffer and counter < MAX: I/O wins.
  - drain_i overrides I/O priority, and overrides the counter.
  - io_request_i dropping while not granted is legal and ignored.
- Illegal: a buffer grant with buf_empty_i = 1 never occurs. Assertion: buf_pop_o implies !buf_empty_i.
- Assertions:
  - mem_request_o never high for two consecutive cycles.
  - Payload stable while in a transfer state.

Test Plan:
- Single I/O store: io_request_i=1, address 0x0000_1000, data 0xDEADBEEF, width 2, buffer empty, mem_done_i at T+3 → mem_request_o high only at T+1 with that payload; io_done_o at T+3; idle_o=1 at T+4.
- Buffer drain: buffer holds 3 entries (A=0x8000_0000, B=0x8000_0004, C=0x8000_0008), done after 1 cycle each → 3 pops, mem_address_o sequence A, B, C, one store every 3 cycles; drained_o=1 after the last done.
- Priority: io_request_i and a non-empty buffer both present in IDLE → I/O granted first, then the buffer head.
- Starvation limit: MAX_IO_BURST=4, io_request_i re-asserted continuously, buffer non-empty → grant order IO, IO, IO, IO, BUF, IO.
- Fence: drain_i=1 with 2 buffered entries and io_request_i=1 → both buffer entries are stored before the I/O grant; drained_o rises before io_done_o.
- Reset mid-transfer: rst_n_i low in BUF_STORE before mem_done_i → mem_request_o=0 and idle_o=1 immediately (asynchronously); no io_done_o; counter=0 after release.
